charattr_ram: RTL
=================

CHARATTR_RAM -- requirements
Module: charattr_ram

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 9: address width; depth DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rd  input  1  read enable.
REQ-006 rd_addr  input  ADDR_W  read address.
REQ-007 rd_data  output  DATA_W  registered read data.
REQ-008 wr  input  1  external write enable.
REQ-009 wr_addr  input  ADDR_W  external write address.
REQ-010 wr_data  input  DATA_W  external write data.
REQ-011 fill_start  input  1  one-cycle request to start a region fill.
REQ-012 fill_base  input  ADDR_W  first address of the fill region.
REQ-013 fill_len  input  ADDR_W+1  number of words to fill, range 0..DEPTH.
REQ-014 fill_value  input  DATA_W  value written to every word of the region.
REQ-015 busy  output  1  high while a fill is in progress.
REQ-016 fill_done  output  1  one-cycle pulse when a fill completes.
REQ-017 wr_dropped  output  1  one-cycle pulse when an external write is discarded.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W, single clock, one read port and one write port, inferable as block RAM.
REQ-019 Read: when rd=1 at edge N, rd_data SHALL show mem[rd_addr] after edge N (1-cycle latency); when rd=0, rd_data SHALL hold its value.
REQ-020 Read-during-write to the same address SHALL return the old (pre-write) data.
REQ-021 Reads SHALL be serviced in every state, including during a fill.
REQ-022 FSM states SHALL be IDLE and FILL only.
REQ-023 IDLE: wr=1 SHALL write wr_data to mem[wr_addr] at that edge.
REQ-024 IDLE, fill_start=1, fill_len>0: the block SHALL latch fill_base, fill_len and fill_value, go to FILL, and assert busy on the next cycle; no external write SHALL occur in that cycle.
REQ-025 IDLE, fill_start=1, fill_len=0: the block SHALL stay in IDLE, perform no fill write, and pulse fill_done the next cycle.
REQ-026 IDLE with fill_start=1 and wr=1 in the same cycle: the fill SHALL win, the write SHALL be discarded, and wr_dropped SHALL pulse.
REQ-027 FILL: one word per cycle SHALL be written with the latched fill_value, starting at the latched base and incrementing the address modulo DEPTH (DEPTH-1 wraps to 0).
REQ-028 FILL: after the last word, the block SHALL return to IDLE; busy SHALL drop and fill_done SHALL pulse on the cycle after the last write.
REQ-029 A fill of fill_len words SHALL take exactly fill_len cycles with busy=1.
REQ-030 FILL: wr=1 SHALL be discarded, no memory change, with wr_dropped pulsing the following cycle.
REQ-031 FILL: fill_start SHALL be ignored.
REQ-032 fill_len=DEPTH SHALL write every word exactly once.
REQ-033 Input changes to fill_base, fill_len or fill_value during FILL SHALL have no effect.

Reset
REQ-034 During reset, rd_data SHALL be 0, busy 0, fill_done 0, wr_dropped 0, and the FSM SHALL be in IDLE.
REQ-035 Reset SHALL NOT initialise memory contents; contents SHALL be undefined until written.
REQ-036 Reset mid-fill SHALL abort the fill immediately, with no further fill writes and no fill_done pulse; words already written SHALL keep their values.
REQ-037 The block SHALL accept rd, wr and fill_start on the first cycle after rst deasserts.

Verification
REQ-038 Write 0x41 at 0x005, then rd at 0x005 -> rd_data=0x41 one cycle after the read edge; with rd=0 afterwards -> rd_data stays 0x41.
REQ-039 Same-edge wr 0x22 and rd at 0x010, where the old value is 0x11 -> rd_data=0x11; next read -> 0x22.
REQ-040 Fill base=0x1FE, len=4, value=0x20 -> 0x1FE, 0x1FF, 0x000 and 0x001 each read 0x20; 0x002 is unchanged; busy high for exactly 4 cycles; fill_done pulses once.
REQ-041 Fill base=0, len=512, with wr at 0x100 mid-fill -> 0x100 reads the fill value, wr_dropped pulses once, fill_start during the fill is ignored.
REQ-042 Fill with len=0 -> no memory change, busy never high, fill_done pulses the next cycle.
REQ-043 rst asserted 3 cycles into a len=8 fill -> busy=0 the next cycle, no fill_done, exactly the first 3 words filled, the rest unchanged.

Source files
------------

// File: rtl/charattr_ram.sv
// Character/attribute RAM with single-port-style write path shared between
// external writes and a hardware region fill engine. One read port, one write
// port, registered read data with read-before-write behaviour.
module charattr_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              fill_done,
    output logic              wr_dropped
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Storage: no reset so the array maps onto block RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] w_fill_addr_nxt;
    logic [ADDR_W:0]   r_fill_remain;
    logic [ADDR_W:0]   w_fill_remain_nxt;
    logic [DATA_W-1:0] r_fill_value;
    logic [DATA_W-1:0] w_fill_value_nxt;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_done;
    logic              w_dropped;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_busy;
    logic              r_fill_done;
    logic              r_wr_dropped;

    assign rd_data    = r_rd_data;
    assign busy       = r_busy;
    assign fill_done  = r_fill_done;
    assign wr_dropped = r_wr_dropped;

    // Next-state logic: arbitrates the single write port between the
    // external writer and the fill engine; a fill request always wins.
    always_comb begin
        w_state_nxt       = r_state;
        w_fill_addr_nxt   = r_fill_addr;
        w_fill_remain_nxt = r_fill_remain;
        w_fill_value_nxt  = r_fill_value;
        w_we              = 1'b0;
        w_waddr           = wr_addr;
        w_wdata           = wr_data;
        w_done            = 1'b0;
        w_dropped         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fill_start) begin
                    w_dropped = wr;
                    if (fill_len != LEN_ZERO) begin
                        w_state_nxt       = ST_FILL;
                        w_fill_addr_nxt   = fill_base;
                        w_fill_remain_nxt = fill_len;
                        w_fill_value_nxt  = fill_value;
                    end else begin
                        // Empty region: nothing to write, report completion.
                        w_done = 1'b1;
                    end
                end else if (wr) begin
                    w_we = 1'b1;
                end else begin
                    w_we = 1'b0;
                end
            end
            ST_FILL: begin
                // External writes and new fill requests are ignored here.
                w_dropped         = wr;
                w_we              = 1'b1;
                w_waddr           = r_fill_addr;
                w_wdata           = r_fill_value;
                w_fill_addr_nxt   = r_fill_addr + ADDR_ONE;
                w_fill_remain_nxt = r_fill_remain - LEN_ONE;
                if (r_fill_remain == LEN_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, fill context and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fill_addr   <= ADDR_ZERO;
            r_fill_remain <= LEN_ZERO;
            r_fill_value  <= DATA_ZERO;
            r_busy        <= 1'b0;
            r_fill_done   <= 1'b0;
            r_wr_dropped  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_addr   <= w_fill_addr_nxt;
            r_fill_remain <= w_fill_remain_nxt;
            r_fill_value  <= w_fill_value_nxt;
            r_busy        <= (w_state_nxt == ST_FILL);
            r_fill_done   <= w_done;
            r_wr_dropped  <= w_dropped;
        end
    end

    // Memory write port; suppressed during reset so an aborted fill stops at once.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read port; same-edge writes are seen as old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= DATA_ZERO;
        end else if (rd) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

endmodule
